uart_word_tx_feeder: RTL and testbench
======================================

# uart_word_tx_feeder

Buffers 32-bit result words from the sparse-matrix datapath in a small FIFO and serializes each word into bytes, least-significant byte first, for the UART byte transmitter. It sits directly upstream of the transmitter and drives its start/data/ready handshake, one byte at a time. Producers see a simple valid/ready push interface and never have to wait on UART timing.

## Interface
- `DEPTH`, default 8: FIFO depth in words; must be a power of 2 and at least 2.
- `clk`  in  1: system clock (50 MHz).
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: the producer offers `in_word`.
- `in_word`  in  32: word to transmit.
- `in_ready`  out  1: FIFO can accept a word; reset value 0 while `rst` is high, 1 after reset.
- `tx_ready`  in  1: the transmitter is idle and can take a byte.
- `tx_start`  out  1: one-cycle registered pulse that launches a byte; reset value 0.
- `tx_data`  out  8: byte to send, held stable from the `tx_start` cycle until the next launch; reset value 8'h00.
- `busy`  out  1: FIFO is non-empty or the FSM is not in IDLE; reset value 0.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy in words; reset value 0.

## Operation
- FIFO
  - A push occurs on an edge where `in_valid && in_ready`.
  - `in_ready = !rst && (level != DEPTH)`.
  - A full FIFO rejects a push even when a pop happens on the same edge.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves `level` unchanged.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
  - IDLE: if the FIFO is non-empty, pop the head into `word_r`, set `byte_idx` to 0, and go to SEND. Otherwise stay.
  - SEND: if `tx_ready` is 1, register `tx_start` to 1 and `tx_data` to `word_r[8*byte_idx +: 8]`, then go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `tx_start` returns to 0. Stay until `tx_ready` is 0, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_ready` is 1.
    - If this is the last byte of the frame: go to IDLE, or straight to a pop when the FIFO is non-empty (same action as IDLE).
    - Otherwise: increment `byte_idx` and go to SEND.
- A frame is 4 bytes: `word[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- `tx_start` is never asserted while in WAIT_BUSY or WAIT_DONE, so a byte can never be double-issued.
- Reset mid-frame:
  - FIFO emptied, FSM forced to IDLE, `byte_idx` cleared, `tx_start`/`tx_data` cleared immediately.
  - The partially sent word is discarded.
  - A byte already accepted by the transmitter completes under the transmitter's own control.

## Timing
- Word accepted into an empty FIFO at edge E0:
  - FSM pops at E1.
  - `tx_start` is high for exactly the cycle after E2.
- With a transmitter that drops `tx_ready` one cycle after start, WAIT_BUSY lasts 1 cycle.
- Inter-byte gap: 2 clk cycles from `tx_ready` rising to the next `tx_start`.
  - One edge leaves WAIT_DONE, one edge registers the launch in SEND.
- Back-to-back words: no idle bytes between frames; the next pop occurs on the edge that ends the previous frame.
- `level` and `in_ready` update on the push/pop edge; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `UART_FEEDER_CHECKSUM_EN` defined:
  - Each frame is 5 bytes; byte 4 is the XOR of the four data bytes.
  - `byte_idx` counts 0–4.
- `UART_FEEDER_CHECKSUM_EN` undefined:
  - Frames are 4 bytes; no checksum logic or register is instantiated.

## Test plan
- Reset, then push `32'hDEADBEEF` with a transmitter model that holds `tx_ready` low for 20 cycles after each start.
  - Required: `tx_data` sequence EF, BE, AD, DE, with one `tx_start` pulse each.
  - With the macro defined, a fifth byte 22 follows.
- Push DEPTH+1 words back-to-back while `tx_ready` is held 0.
  - Required: `in_ready` drops after DEPTH pushes and `level == DEPTH`.
  - The extra word is not accepted; it is accepted only after the first pop.
- Push on the same edge the FSM pops from a full FIFO.
  - Required: push rejected, `level == DEPTH-1` afterwards.
- Hold `tx_ready` at 1 permanently (stuck transmitter).
  - Required: exactly one `tx_start` pulse, FSM parked in WAIT_BUSY, no further starts.
- Assert `rst` for 1 cycle during byte 2 of a 3-word burst.
  - Required: `tx_start` = 0, `level` = 0, `busy` = 0 immediately.
  - A new word pushed afterwards is sent from byte 0.
- Push 16 random words with random transmitter busy lengths of 1–50 cycles.
  - Required: the scoreboard's byte stream equals the little-endian words in order, with no drops or duplicates.

Source files
------------

// File: rtl/uart_word_tx_feeder.sv
// uart_word_tx_feeder
//   Buffers 32-bit result words in a small FIFO and feeds them, least
//   significant byte first, to a UART byte transmitter via its
//   start/data/ready handshake.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   in_valid  producer offers in_word
//   in_word   32-bit word to transmit
//   in_ready  FIFO can accept a word (low while rst is high)
//   tx_ready  transmitter idle, can take a byte
//   tx_start  one-cycle registered launch pulse
//   tx_data   byte being sent, held until the next launch
//   busy      FIFO non-empty or FSM not idle
//   level     FIFO occupancy in words
//
// Build option
//   UART_FEEDER_CHECKSUM_EN : append a fifth byte, the XOR of the four data
//                             bytes, to every frame.
module uart_word_tx_feeder #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [31:0]              in_word,
   output logic                     in_ready,
   input  logic                     tx_ready,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef UART_FEEDER_CHECKSUM_EN
   localparam int unsigned      IDXW     = 3;
   localparam logic [IDXW-1:0]  LAST_IDX = 3'd4;
`else
   localparam int unsigned      IDXW     = 2;
   localparam logic [IDXW-1:0]  LAST_IDX = 2'd3;
`endif
   localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   // FIFO storage and bookkeeping
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            push;
   logic            pop;
   logic            empty;

   // Serializer state
   state_t          state, state_n;
   logic [31:0]     word_r, word_n;
   logic [IDXW-1:0] byte_idx, idx_n;
   logic            start_n;
   logic [7:0]      data_n;
   logic [7:0]      cur_byte;
   logic            last_byte;

   assign empty     = (count == '0);
   // Depends only on rst and registered count: no path from in_valid.
   // A full FIFO refuses a push even on a pop edge.
   assign in_ready  = !rst && (count != LVL_FULL);
   assign push      = in_valid && in_ready;
   assign level     = count;
   assign busy      = !empty || (state != IDLE);
   assign last_byte = (byte_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + LVL_ONE;
         end else if (!push && pop) begin
            count <= count - LVL_ONE;
         end
      end
   end

   always_comb begin
      cur_byte = word_r[{byte_idx[1:0], 3'b000} +: 8];
`ifdef UART_FEEDER_CHECKSUM_EN
      if (byte_idx == LAST_IDX) begin
         cur_byte = word_r[7:0] ^ word_r[15:8] ^ word_r[23:16] ^ word_r[31:24];
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         word_r   <= '0;
         byte_idx <= '0;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         state    <= state_n;
         word_r   <= word_n;
         byte_idx <= idx_n;
         tx_start <= start_n;
         tx_data  <= data_n;
      end
   end

   always_comb begin
      state_n = state;
      word_n  = word_r;
      idx_n   = byte_idx;
      start_n = 1'b0;
      data_n  = tx_data;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               word_n  = mem[rd_ptr];
               idx_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               start_n = 1'b1;
               data_n  = cur_byte;
               state_n = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!tx_ready) begin
               state_n = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               if (last_byte) begin
                  // Frame done: chain straight into the next pop so
                  // back-to-back words have no idle gap.
                  if (!empty) begin
                     pop     = 1'b1;
                     word_n  = mem[rd_ptr];
                     idx_n   = '0;
                     state_n = SEND;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  idx_n   = byte_idx + IDX_ONE;
                  state_n = SEND;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_word_tx_feeder.sv
// Testbench for uart_word_tx_feeder: directed scenarios with a behavioural
// UART transmitter that records every launched byte.
module tb_uart_word_tx_feeder;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef UART_FEEDER_CHECKSUM_EN
   localparam int FB = 5;
`else
   localparam int FB = 4;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [31:0]   in_word;
   logic          in_ready;
   logic          tx_ready;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          busy;
   logic [LW-1:0] level;

   uart_word_tx_feeder #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_word  (in_word),
      .in_ready (in_ready),
      .tx_ready (tx_ready),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy),
      .level    (level)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Transmitter model: mode 0 = busy for busy_len (or random 1..50) cycles
   // after each start, mode 1 = ready held low, mode 2 = ready held high.
   int         tx_mode   = 0;
   int         busy_len  = 20;
   bit         busy_rand = 0;
   int         tx_cnt    = 0;
   int         cyc       = 0;
   logic [7:0] sb [$];
   int         st_cyc [$];

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_FM1  = LW'(DEPTH - 1);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (tx_start === 1'b1) begin
            sb.push_back(tx_data);
            st_cyc.push_back(cyc);
         end
         case (tx_mode)
            0: begin
               if (tx_start === 1'b1) begin
                  tx_ready = 1'b0;
                  tx_cnt   = busy_rand ? int'($urandom_range(1, 50)) : busy_len;
               end else if (tx_cnt > 0) begin
                  tx_cnt--;
                  if (tx_cnt == 0) tx_ready = 1'b1;
               end else begin
                  tx_ready = 1'b1;
               end
            end
            1: begin
               tx_ready = 1'b0;
               tx_cnt   = 0;
            end
            default: begin
               tx_ready = 1'b1;
               tx_cnt   = 0;
            end
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] exp_byte(input logic [31:0] w, input int idx);
      case (idx)
         0: return w[7:0];
         1: return w[15:8];
         2: return w[23:16];
         3: return w[31:24];
         default: return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_word = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++;
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      n_checks++;
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single_word();
      logic [31:0] w = 32'hDEADBEEF;
      int n;
      tx_mode = 0; busy_len = 20; busy_rand = 0;
      repeat (2) @(negedge clk);
      sb.delete(); st_cyc.delete();
      in_valid = 1'b1; in_word = w;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level_after_push: got %0d want 1", level); end
      @(negedge clk);
      n_checks++;
      if (level !== '0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d want 0", level); end
      n_checks++;
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b want 0", tx_start); end
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_latency: got %b want 1", tx_start); end
      n_checks++;
      if (tx_data !== 8'hEF) begin n_fail++; $display("FAIL single_first_byte: got %h want ef", tx_data); end
      @(negedge clk);
      n_checks++;
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b want 0", tx_start); end
      n_checks++;
      if (tx_data !== 8'hEF) begin n_fail++; $display("FAIL single_data_hold: got %h want ef", tx_data); end
      n = 0;
      while ((sb.size() < FB || busy) && n < 1000) begin @(negedge clk); n++; end
      n_checks++;
      if (sb.size() != FB) begin n_fail++; $display("FAIL single_byte_count: got %0d want %0d", sb.size(), FB); end
      for (int i = 0; i < FB; i++) begin
         logic [7:0] got = (i < sb.size()) ? sb[i] : 8'hxx;
         n_checks++;
         if (got !== exp_byte(w, i)) begin
            n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp_byte(w, i));
         end
      end
      begin
         int gap = (st_cyc.size() >= 2) ? st_cyc[1] - st_cyc[0] : -1;
         n_checks++;
         if (gap != busy_len + 2) begin n_fail++; $display("FAIL single_start_spacing: got %0d want %0d", gap, busy_len + 2); end
      end
   endtask

   task automatic test_full();
      logic [31:0] pre  = 32'h0BADF00D;
      logic [31:0] base = 32'hC0DE0000;
      logic [7:0]  exp_q [$];
      int n;
      tx_mode = 1;
      repeat (2) @(negedge clk);
      sb.delete();
      in_valid = 1'b1; in_word = pre;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (level !== '0) begin n_fail++; $display("FAIL full_pre_popped: got %0d want 0", level); end
      for (int i = 0; i <= int'(DEPTH); i++) begin
         n_checks++;
         if (in_ready !== (i < int'(DEPTH))) begin
            n_fail++; $display("FAIL full_in_ready_%0d: got %b want %b", i, in_ready, (i < int'(DEPTH)));
         end
         in_valid = 1'b1; in_word = base + 32'(i);
         @(negedge clk);
      end
      n_checks++;
      if (level !== LVL_FULL) begin n_fail++; $display("FAIL full_level: got %0d want %0d", level, DEPTH); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_low: got %b want 0", in_ready); end
      // Extra word stays offered; first pop must not let it in on that edge.
      tx_mode = 0; busy_len = 3; busy_rand = 0;
      n = 0;
      while (level === LVL_FULL && n < 500) begin @(negedge clk); n++; end
      n_checks++;
      if (level !== LVL_FM1) begin n_fail++; $display("FAIL full_pop_push_reject: got %0d want %0d", level, DEPTH - 1); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (level !== LVL_FULL) begin n_fail++; $display("FAIL full_extra_accepted: got %0d want %0d", level, DEPTH); end
      for (int b = 0; b < FB; b++) exp_q.push_back(exp_byte(pre, b));
      for (int i = 0; i <= int'(DEPTH); i++)
         for (int b = 0; b < FB; b++) exp_q.push_back(exp_byte(base + 32'(i), b));
      n = 0;
      while ((sb.size() < exp_q.size() || busy) && n < 3000) begin @(negedge clk); n++; end
      n_checks++;
      if (sb.size() != exp_q.size()) begin n_fail++; $display("FAIL full_byte_count: got %0d want %0d", sb.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [7:0] got = (i < sb.size()) ? sb[i] : 8'hxx;
         n_checks++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL full_stream_%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_stuck();
      logic [7:0] first;
      tx_mode = 2;
      repeat (2) @(negedge clk);
      sb.delete();
      in_valid = 1'b1; in_word = 32'hA5A50001;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (sb.size() != 1) begin n_fail++; $display("FAIL stuck_start_count: got %0d want 1", sb.size()); end
      first = (sb.size() > 0) ? sb[0] : 8'hxx;
      n_checks++;
      if (first !== 8'h01) begin n_fail++; $display("FAIL stuck_byte: got %h want 01", first); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL stuck_busy: got %b want 1", busy); end
      n_checks++;
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL stuck_start_low: got %b want 0", tx_start); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tx_mode = 0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL stuck_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] w = 32'h11223344;
      int n;
      tx_mode = 0; busy_len = 5; busy_rand = 0;
      repeat (3) @(negedge clk);
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_word = 32'h55000000 + 32'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      n = 0;
      while (sb.size() < 2 && n < 500) begin @(negedge clk); n++; end
      n_checks++;
      if (tx_start !== 1'b1) begin n_fail++; $display("FAIL mid_start_before_rst: got %b want 1", tx_start); end
      rst = 1'b1;
      #1;
      n_checks++;
      if (tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tx_start: got %b want 0", tx_start); end
      n_checks++;
      if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx_data: got %h want 00", tx_data); end
      n_checks++;
      if (level !== '0) begin n_fail++; $display("FAIL mid_rst_level: got %0d want 0", level); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (tx_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      sb.delete();
      in_valid = 1'b1; in_word = w;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while ((sb.size() < FB || busy) && n < 1000) begin @(negedge clk); n++; end
      n_checks++;
      if (sb.size() != FB) begin n_fail++; $display("FAIL mid_after_count: got %0d want %0d", sb.size(), FB); end
      for (int i = 0; i < FB; i++) begin
         logic [7:0] got = (i < sb.size()) ? sb[i] : 8'hxx;
         n_checks++;
         if (got !== exp_byte(w, i)) begin n_fail++; $display("FAIL mid_after_byte%0d: got %h want %h", i, got, exp_byte(w, i)); end
      end
   endtask

   task automatic test_random();
      logic [31:0] rw [16];
      int n;
      tx_mode = 0; busy_rand = 1;
      repeat (2) @(negedge clk);
      sb.delete();
      for (int i = 0; i < 16; i++) rw[i] = $urandom();
      for (int i = 0; i < 16; i++) begin
         n = 0;
         while (!in_ready && n < 5000) begin @(negedge clk); n++; end
         in_valid = 1'b1; in_word = rw[i];
         @(negedge clk);
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      n = 0;
      while ((sb.size() < 16 * FB || busy) && n < 20000) begin @(negedge clk); n++; end
      busy_rand = 0;
      n_checks++;
      if (sb.size() != 16 * FB) begin n_fail++; $display("FAIL rand_byte_count: got %0d want %0d", sb.size(), 16 * FB); end
      for (int i = 0; i < 16 * FB; i++) begin
         logic [7:0] want = exp_byte(rw[i / FB], i % FB);
         logic [7:0] got  = (i < sb.size()) ? sb[i] : 8'hxx;
         n_checks++;
         if (got !== want) begin n_fail++; $display("FAIL rand_stream_%0d: got %h want %h", i, got, want); end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full();
      test_stuck();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
